// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: machine width, canonical NOP, default reset PC and fetch FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: valid/ready request channel, valid-only response channel.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch: PC + single-outstanding imem FSM feeding a registered IF/ID slot; latency = memory latency + 1.
// A stalled full slot blocks new requests; a redirect flushes the slot and discards any in-flight response.
module fetch_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = riscv_pkg::DEFAULT_RESET_PC,
  parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  fetch_stage_if.master              imem,
  input  logic                       redirect_valid,
  input  logic [riscv_pkg::XLEN-1:0] redirect_target,
  input  logic                       stall,
  output logic                       if_valid,
  output logic [riscv_pkg::XLEN-1:0] if_instr,
  output logic [riscv_pkg::XLEN-1:0] if_pc
);
  import riscv_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            slot_free;
  logic            req_hs;

  assign slot_free = !if_valid || !stall;

  // Request only from FETCH into a slot that can take the result, and never
  // in a redirect cycle since the address is about to change.
  assign imem.imem_req_valid = !rst && (state == FETCH) && slot_free && !redirect_valid;
  assign imem.imem_req_addr  = pc;
  assign req_hs              = imem.imem_req_valid && imem.imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      pc       <= align_word(redirect_target);
      case (state)
        // req_valid is masked by redirect, so DRAIN here only covers a memory
        // that latched the request early anyway.
        FETCH:   state <= req_hs ? DRAIN : FETCH;
        WAIT:    state <= imem.imem_rsp_valid ? FETCH : DRAIN;
        // A response landing now is the one being drained; waiting for another would deadlock.
        DRAIN:   state <= imem.imem_rsp_valid ? FETCH : DRAIN;
        default: state <= FETCH;
      endcase
    end else begin
      if (if_valid && !stall) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
      case (state)
        FETCH: begin
          if (req_hs) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            if_valid <= 1'b1;
            if_instr <= imem.imem_rsp_data;
            if_pc    <= pc;
            pc       <= pc + 32'd4;
            state    <= FETCH;
          end
        end
        DRAIN: begin
          if (imem.imem_rsp_valid) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle table for fetch_stage with a one-cycle-latency memory model and a scoreboard of loaded slot words.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect_valid, stall, if_valid;
  logic [31:0] redirect_target, if_instr, if_pc;
  fetch_stage_if bus ();

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem(bus),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  logic        rst2, redirect_valid2, stall2, if_valid2;
  logic [31:0] redirect_target2, if_instr2, if_pc2;
  fetch_stage_if bus2 ();

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .imem(bus2),
    .redirect_valid(redirect_valid2), .redirect_target(redirect_target2), .stall(stall2),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2)
  );

  typedef struct {
    logic        rst, rv;
    logic [31:0] rt;
    logic        st, rdy, rsp_en;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv, chk_pc;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rt,
                              input logic st, input logic rdy, input logic en,
                              input logic erv, input logic [31:0] era,
                              input logic eiv, input logic cpc, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.rv = rv; v.rt = rt; v.st = st; v.rdy = rdy; v.rsp_en = en;
    v.e_rv = erv; v.e_ra = era; v.e_iv = eiv; v.chk_pc = cpc; v.e_pc = epc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0010_0093;
      32'h4:   return 32'h0050_0093;
      32'h8:   return 32'h00a0_0113;
      default: return {a[19:0], 12'h093};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t        v;
    sb_t         s;
    sb_t         last;
    logic        pending, stale, delivered, pushed, pop_due;
    logic [31:0] pend_addr;

    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; stall = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    rst2 = 1'b1; redirect_valid2 = 1'b0; redirect_target2 = '0; stall2 = 1'b0;
    bus2.imem_req_ready = 1'b0; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = '0;
    pending = 1'b0; stale = 1'b0; pop_due = 1'b0; pend_addr = '0;
    last.pc = '0; last.instr = '0;

    //                 rst rv rt        st rdy en  erv era        eiv cpc epc
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0,  0, 32'h0,     0, 1, 32'h0));    // reset state
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  1, 32'h0,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  0, 32'h0,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  1, 32'h4,     1, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  0, 32'h0,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  0, 32'h0,     1, 1, 32'h4));    // stall x3
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  0, 32'h0,     1, 1, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  0, 32'h0,     1, 1, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  1, 32'h8,     1, 1, 32'h4));
    vecs.push_back(mk(0, 1, 32'h103,  0, 1, 0,  0, 32'h0,     0, 0, 32'h0));    // redirect in WAIT
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  0, 32'h0,     0, 0, 32'h0));    // late rsp drained
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  1, 32'h100,   0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h200,  0, 1, 1,  0, 32'h0,     0, 0, 32'h0));    // redirect + rsp
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  1, 32'h200,   0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  0, 32'h0,     0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h300,  0, 1, 1,  0, 32'h0,     1, 1, 32'h200));  // redirect in FETCH
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  1, 32'h300,   0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  0, 32'h0,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 1,  1, 32'h304,   1, 1, 32'h300));  // ready low
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 1,  1, 32'h304,   0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  1, 32'h304,   0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  0, 32'h0,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  1, 32'h308,   1, 1, 32'h304));
    vecs.push_back(mk(1, 0, 32'h0,    0, 1, 0,  0, 32'h0,     0, 0, 32'h0));    // reset in WAIT
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 1,  1, 32'h0,     0, 1, 32'h0));    // stale rsp ignored
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 1,  1, 32'h0,     0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  1, 32'h0,     0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 1,  0, 32'h0,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 1,  1, 32'h4,     1, 1, 32'h0));

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; redirect_valid = v.rv; redirect_target = v.rt; stall = v.st;
      bus.imem_req_ready = v.rdy;
      delivered = pending && v.rsp_en;
      bus.imem_rsp_valid = delivered;
      bus.imem_rsp_data  = delivered ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      pushed = 1'b0;
      if (delivered) begin
        if (!stale && !v.rv && !v.rst) begin
          s.pc = pend_addr; s.instr = mem_word(pend_addr);
          sb_q.push_back(s);
          pushed = 1'b1;
        end
        pending = 1'b0;
        stale   = 1'b0;
      end else if (pending && (v.rv || v.rst)) begin
        stale = 1'b1;
      end

      @(negedge clk);
      chk($sformatf("req_valid[%0d]", i), {31'b0, bus.imem_req_valid}, {31'b0, v.e_rv});
      if (v.e_rv) chk($sformatf("req_addr[%0d]", i), bus.imem_req_addr, v.e_ra);
      chk($sformatf("if_valid[%0d]", i), {31'b0, if_valid}, {31'b0, v.e_iv});
      if (!v.e_iv) chk($sformatf("if_instr_nop[%0d]", i), if_instr, NOP_INSTR);
      if (v.chk_pc) chk($sformatf("if_pc[%0d]", i), if_pc, v.e_pc);
      if (pop_due) begin
        last = sb_q.pop_front();
        chk($sformatf("sb_pc[%0d]", i), if_pc, last.pc);
        chk($sformatf("sb_instr[%0d]", i), if_instr, last.instr);
      end else if (v.e_iv && v.chk_pc) begin
        chk($sformatf("hold_instr[%0d]", i), if_instr, last.instr);
      end
      pop_due = pushed;
      if (bus.imem_req_valid && v.rdy && !v.rst) begin
        pending   = 1'b1;
        pend_addr = bus.imem_req_addr;
      end
      @(posedge clk); #1;
    end
    chk("sb_drained", sb_q.size(), 0);

    // PC wrap from the top word of the address space.
    rst2 = 1'b0; bus2.imem_req_ready = 1'b1;
    @(negedge clk);
    chk("wrap_req_valid0", {31'b0, bus2.imem_req_valid}, 32'd1);
    chk("wrap_req_addr0", bus2.imem_req_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    bus2.imem_req_ready = 1'b0; bus2.imem_rsp_valid = 1'b1; bus2.imem_rsp_data = 32'h0070_0093;
    @(negedge clk);
    chk("wrap_wait_no_req", {31'b0, bus2.imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    bus2.imem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("wrap_if_valid", {31'b0, if_valid2}, 32'd1);
    chk("wrap_if_pc", if_pc2, 32'hFFFF_FFFC);
    chk("wrap_if_instr", if_instr2, 32'h0070_0093);
    chk("wrap_req_addr1", bus2.imem_req_addr, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
